// File: rtl/ddr3_pkg.sv
// Shared types and default parameters for the DDR3 MMCM fine-phase-shift sequencer.
package ddr3_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PULSE,
        S_WAIT,
        S_GAP
    } ps_state_e;

    localparam int DEF_TAP_W   = 10;
    localparam int DEF_PS_MIN  = -448;
    localparam int DEF_PS_MAX  = 447;
    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_GAP     = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr3_ps_timer.sv
// Loadable down-counter shared by the PSDONE timeout and the inter-step gap.
module ddr3_ps_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    // A load takes priority over counting so a phase can re-arm in the cycle it ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/ddr3_ps_ctrl.sv
// Walks the DDR3 clock MMCM one fine-phase tap at a time toward a clamped signed target.
module ddr3_ps_ctrl
    import ddr3_pkg::*;
#(
    parameter int TAP_W   = DEF_TAP_W,
    parameter int PS_MIN  = DEF_PS_MIN,
    parameter int PS_MAX  = DEF_PS_MAX,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int GAP     = DEF_GAP
) (
    input  logic                    clk_app,
    input  logic                    sys_rst_n,
    input  logic                    mmcm_locked,
    input  logic                    req_valid,
    input  logic signed [TAP_W-1:0] req_target,
    output logic                    req_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic signed [TAP_W-1:0] cur_tap,
    output logic                    PSEN,
    output logic                    PSINCDEC,
    input  logic                    PSDONE
);

    localparam int CNT_W = $clog2(max2(TIMEOUT, GAP)) + 1;
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);
    localparam logic signed [TAP_W-1:0] MIN_TAP = TAP_W'(PS_MIN);
    localparam logic signed [TAP_W-1:0] MAX_TAP = TAP_W'(PS_MAX);
    localparam logic [TAP_W-1:0] ONE = {{(TAP_W-1){1'b0}}, 1'b1};

    ps_state_e state_q, state_d;
    logic signed [TAP_W-1:0] cur_tap_q, cur_tap_d;
    logic signed [TAP_W-1:0] tgt_q, tgt_d;
    logic signed [TAP_W-1:0] clamped;
    logic incdec_q, incdec_d;
    logic err_q, err_d;
    logic tmr_load, tmr_en, tmr_exp;
    logic [CNT_W-1:0] tmr_val;

    always_comb begin
        clamped = req_target;
        if (req_target < MIN_TAP) begin
            clamped = MIN_TAP;
        end else if (req_target > MAX_TAP) begin
            clamped = MAX_TAP;
        end
    end

    ddr3_ps_timer #(.W(CNT_W)) u_timer (
        .clk_i      (clk_app),
        .rst_ni     (sys_rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .expired_o  (tmr_exp)
    );

    // Lock loss overrides everything: an MMCM reset discards the accumulated phase.
    always_comb begin
        state_d   = state_q;
        cur_tap_d = cur_tap_q;
        tgt_d     = tgt_q;
        incdec_d  = incdec_q;
        err_d     = err_q;
        done      = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = TO_LOAD;
        tmr_en    = 1'b0;
        if (!mmcm_locked) begin
            cur_tap_d = '0;
            state_d   = S_IDLE;
            if (state_q != S_IDLE) begin
                err_d = 1'b1;
                done  = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        tgt_d   = clamped;
                        err_d   = 1'b0;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cur_tap_q == tgt_q) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        incdec_d = (tgt_q > cur_tap_q);
                        state_d  = S_PULSE;
                    end
                end
                S_PULSE: begin
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                    state_d  = S_WAIT;
                end
                S_WAIT: begin
                    tmr_en = 1'b1;
                    // PSDONE arriving in the expiry cycle still counts as a completed step.
                    if (PSDONE) begin
                        cur_tap_d = incdec_q ? (cur_tap_q + ONE) : (cur_tap_q - ONE);
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_LOAD;
                        state_d   = S_GAP;
                    end else if (tmr_exp) begin
                        err_d   = 1'b1;
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_GAP: begin
                    tmr_en = 1'b1;
                    if (tmr_exp) begin
                        state_d = S_CHECK;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_app or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            cur_tap_q <= '0;
            tgt_q     <= '0;
            incdec_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_tap_q <= cur_tap_d;
            tgt_q     <= tgt_d;
            incdec_q  <= incdec_d;
            err_q     <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && mmcm_locked;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign cur_tap   = cur_tap_q;
    assign PSEN      = (state_q == S_PULSE) && mmcm_locked;
    assign PSINCDEC  = incdec_q;

endmodule
